smi_flit_width_reducer: RTL and testbench
=========================================

// Module: smi_flit_width_reducer
// PURPOSE
// - Downstream neighbour of the SMI frame dropper. Splits each wide SMI flit into
//   2^k narrow flits for a narrower downstream link, preserving frame boundaries.
// - Recomputes EOFC for the narrow link, drops unused tail beats of the final
//   flit, and carries the per-frame dropped-frame flag alongside the data.
// PARAMETERS
// - InFlitWidth    8  input flit width in bytes, power of two, 2..64
// - OutFlitWidth   4  output flit width in bytes, power of two, < InFlitWidth
// - Ratio          InFlitWidth/OutFlitWidth  derived; never overridden
// - BeatIndexSize  clog2(Ratio), minimum 1     derived
// PORTS
// - clk            in   1               rising-edge clock
// - arstn          in   1               async active-low reset
// - dataInValid    in   1               input flit valid
// - dataInEofc     in   8               0 = body flit; 1..InFlitWidth = last flit, valid byte count
// - dataIn         in   InFlitWidth*8   input flit; byte 0 in bits [7:0]
// - dataInFlag     in   1               frame-dropped flag from the dropper, sampled with each flit
// - dataInStop     out  1               input backpressure
// - dataOutValid   out  1               output flit valid
// - dataOutEofc    out  8               0 = body; 1..OutFlitWidth = last flit, valid byte count
// - dataOut        out  OutFlitWidth*8  output flit
// - dataOutFlag    out  1               frame-dropped flag for the current output flit
// - dataOutStop    in   1               output backpressure
// BEHAVIOUR
// - Handshake: a transfer occurs on a rising edge where valid=1 and stop=0. Valid
//   never depends combinatorially on stop. Data/eofc/flag hold while valid & stop.
// - Reset (arstn=0, async assert, sync release): bufValid=0, beatIdx=0, so
//   dataOutValid=0 and dataInStop=0. Data registers are not reset. Reset mid-frame
//   discards the held flit. The next accepted flit is treated as a new frame start.
// - Storage: one held input flit (bufData, bufEofc, bufFlag, bufValid) and a
//   beatIdx counter. Outputs are combinational from these registers only.
// - lastBeats = (bufEofc==0) ? Ratio : ceil(min(bufEofc,InFlitWidth)/OutFlitWidth).
//   EOFC values > InFlitWidth are clipped to InFlitWidth.
// - dataOut = bufData[beatIdx*OutFlitWidth*8 +: OutFlitWidth*8]. dataOutFlag = bufFlag.
// - finalBeat = (beatIdx == lastBeats-1).
//   - dataOutEofc = 0 when bufEofc==0 or ~finalBeat.
//   - Otherwise dataOutEofc = clippedEofc - beatIdx*OutFlitWidth, which is in 1..OutFlitWidth.
// - On an output transfer:
//   - ~finalBeat: beatIdx+1.
//   - finalBeat: beatIdx=0 and bufValid=0, unless an input transfer occurs in the
//     same cycle, in which case the buffer reloads.
// - dataInStop = bufValid & ~(finalBeat & ~dataOutStop). This gives back-to-back
//   flits with no bubble: a sustained rate of 1 output beat per cycle.
// - Latency: input transfer at edge N -> dataOutValid=1 after edge N (first beat visible in cycle N+1).
// - Input is empty: dataOutValid=0. beatIdx cannot advance.
// - Unused tail beats of the last flit are never emitted.
// - dataInFlag is registered per input flit. No frame-level flag re-timing is performed.
// STRUCTURE
// - Shared package: SMI_EOFC_WIDTH=8, the eofc clip/beat-count function, and the
//   log2 helper used for the derived parameters.
// - Single module, no sub-modules. The beat mux is an indexed part-select.
// TESTING
// - 8->4, 3-flit frame (eofc 0,0,8), stop=0 -> 6 output beats, eofc 0,0,0,0,0,4, one beat/cycle, no bubbles.
// - Last flit eofc=3 -> one beat, eofc=3. Last flit eofc=5 -> two beats, eofc 0 then 1. dataInStop correct on each.
// - dataOutStop held high 5 cycles mid-frame -> dataOut/eofc/flag stable. dataInStop=1. No beat lost or duplicated.
// - Back-to-back frames with flags 1 then 0 -> dataOutFlag=1 on all beats of frame A and 0 on all beats of frame B.
// - arstn pulsed low while beatIdx=1 -> dataOutValid=0 immediately; after release the next frame emits from beat 0.
// - Random valid/stop, eofc 1..8, 8->2 and 16->4 builds -> scoreboard byte stream equals input, trimmed to eofc.

Source files
------------

// File: rtl/smi_flit_width_reducer_pkg.sv
// smi_flit_width_reducer_pkg: shared EOFC width, clip/beat-count and log2 helpers
package smi_flit_width_reducer_pkg;
  localparam int SMI_EOFC_WIDTH = 8;
  typedef logic [SMI_EOFC_WIDTH-1:0] smi_eofc_t;
  function automatic int smi_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic smi_eofc_t smi_clip_eofc(input smi_eofc_t eofc, input int flit_width);
    return (int'(eofc) > flit_width) ? smi_eofc_t'(flit_width) : eofc;
  endfunction
  function automatic smi_eofc_t smi_beat_count(input smi_eofc_t eofc, input int in_width, input int out_width);
    return (eofc == '0) ? smi_eofc_t'(in_width / out_width)
                        : smi_eofc_t'((int'(smi_clip_eofc(eofc, in_width)) + out_width - 1) / out_width);
  endfunction
endpackage

// File: rtl/smi_flit_width_reducer_if.sv
// smi_flit_width_reducer_if: SMI flit stream with valid/stop handshake and dropped-frame flag
interface smi_flit_width_reducer_if #(parameter int FlitWidth = 4);
  import smi_flit_width_reducer_pkg::*;
  logic valid;
  smi_eofc_t eofc;
  logic [FlitWidth*8-1:0] data;
  logic flag;
  logic stop;
  modport master(output valid, eofc, data, flag, input stop);
  modport slave(input valid, eofc, data, flag, output stop);
endinterface

// File: rtl/smi_flit_width_reducer.sv
// smi_flit_width_reducer: splits each wide SMI flit into narrow beats, recomputing EOFC
module smi_flit_width_reducer
  import smi_flit_width_reducer_pkg::*;
#(
  parameter int InFlitWidth = 8,
  parameter int OutFlitWidth = 4
) (
  input logic clk,
  input logic arstn,
  smi_flit_width_reducer_if.slave in_if,
  smi_flit_width_reducer_if.master out_if
);
  localparam int Ratio = InFlitWidth / OutFlitWidth;
  localparam int BeatIndexSize = smi_log2(Ratio);
  localparam int OutBits = OutFlitWidth * 8;
  logic [InFlitWidth*8-1:0] buf_data_q, buf_data_d;
  smi_eofc_t buf_eofc_q, buf_eofc_d;
  logic buf_flag_q, buf_flag_d;
  logic buf_valid_q, buf_valid_d;
  logic [BeatIndexSize-1:0] beat_idx_q, beat_idx_d;
  smi_eofc_t clipped_eofc, last_beats;
  logic final_beat, in_fire, out_fire;
  assign clipped_eofc = smi_clip_eofc(buf_eofc_q, InFlitWidth);
  assign last_beats = smi_beat_count(buf_eofc_q, InFlitWidth, OutFlitWidth);
  assign final_beat = int'(beat_idx_q) == int'(last_beats) - 1;
  assign out_if.valid = buf_valid_q;
  assign out_if.data = buf_data_q[int'(beat_idx_q)*OutBits +: OutBits];
  assign out_if.flag = buf_flag_q;
  assign out_if.eofc = (buf_eofc_q == '0 || !final_beat) ? '0
                     : smi_eofc_t'(int'(clipped_eofc) - int'(beat_idx_q) * OutFlitWidth);
  // the buffer may reload on the same edge its final beat leaves, so frames stream without bubbles
  assign in_if.stop = buf_valid_q & ~(final_beat & ~out_if.stop);
  assign in_fire = in_if.valid & ~in_if.stop;
  assign out_fire = buf_valid_q & ~out_if.stop;
  // next state: load on input transfer, otherwise step through beats and release after the final one
  always_comb begin
    buf_data_d = in_fire ? in_if.data : buf_data_q;
    buf_eofc_d = in_fire ? in_if.eofc : buf_eofc_q;
    buf_flag_d = in_fire ? in_if.flag : buf_flag_q;
    buf_valid_d = in_fire | (buf_valid_q & ~(out_fire & final_beat));
    beat_idx_d = (in_fire | (out_fire & final_beat)) ? '0
               : out_fire ? BeatIndexSize'(int'(beat_idx_q) + 1) : beat_idx_q;
  end
  // control state: reset discards any held flit and restarts at beat 0
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      buf_valid_q <= 1'b0;
      beat_idx_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      beat_idx_q <= beat_idx_d;
    end
  end
  // payload registers are qualified by buf_valid_q and need no reset
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_eofc_q <= buf_eofc_d;
    buf_flag_q <= buf_flag_d;
  end
endmodule

// File: tb/tb_smi_flit_width_reducer.sv
// tb_smi_flit_width_reducer: directed 8->4 vectors plus random 8->2 and 16->4 byte-stream scoreboards
module tb_smi_flit_width_reducer;
  import smi_flit_width_reducer_pkg::*;
  localparam int NRAND = 120;
  typedef struct packed {
    logic iv; logic [7:0] ie; logic [63:0] id; logic ifl; logic os;
    logic x_is; logic x_ov; logic [31:0] x_od; logic [7:0] x_oe; logic x_of;
  } vec_t;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [9:0] b_exp[$], b_got[$], c_exp[$], c_got[$];
  always #5 clk = ~clk;
  smi_flit_width_reducer_if #(.FlitWidth(8)) a_in();
  smi_flit_width_reducer_if #(.FlitWidth(4)) a_out();
  smi_flit_width_reducer_if #(.FlitWidth(8)) b_in();
  smi_flit_width_reducer_if #(.FlitWidth(2)) b_out();
  smi_flit_width_reducer_if #(.FlitWidth(16)) c_in();
  smi_flit_width_reducer_if #(.FlitWidth(4)) c_out();
  smi_flit_width_reducer #(.InFlitWidth(8), .OutFlitWidth(4)) u_a (.clk(clk), .arstn(arstn), .in_if(a_in), .out_if(a_out));
  smi_flit_width_reducer #(.InFlitWidth(8), .OutFlitWidth(2)) u_b (.clk(clk), .arstn(arstn), .in_if(b_in), .out_if(b_out));
  smi_flit_width_reducer #(.InFlitWidth(16), .OutFlitWidth(4)) u_c (.clk(clk), .arstn(arstn), .in_if(c_in), .out_if(c_out));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] flit(input logic [7:0] b);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = b + 8'(i);
    return f;
  endfunction
  function automatic vec_t vec(input logic iv, input logic [7:0] ie, input logic [63:0] id, input logic ifl,
                               input logic os, input logic xis, input logic xov, input logic [31:0] xod,
                               input logic [7:0] xoe, input logic xof);
    return '{iv, ie, id, ifl, os, xis, xov, xod, xoe, xof};
  endfunction
  task automatic run_vec(input string name, input vec_t v);
    @(negedge clk);
    a_in.valid = v.iv;
    a_in.eofc = v.ie;
    a_in.data = v.id;
    a_in.flag = v.ifl;
    a_out.stop = v.os;
    #1;
    check({name, "_is"}, 64'(a_in.stop), 64'(v.x_is));
    check({name, "_ov"}, 64'(a_out.valid), 64'(v.x_ov));
    if (v.x_ov) begin
      check({name, "_od"}, 64'(a_out.data), 64'(v.x_od));
      check({name, "_oe"}, 64'(a_out.eofc), 64'(v.x_oe));
      check({name, "_of"}, 64'(a_out.flag), 64'(v.x_of));
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (b_in.valid && !b_in.stop)
      for (int i = 0; i < 8; i++)
        if (b_in.eofc == 0 || i < int'(b_in.eofc))
          b_exp.push_back({b_in.eofc != 0 && i == int'(b_in.eofc) - 1, b_in.flag, b_in.data[i*8 +: 8]});
    if (b_out.valid && !b_out.stop)
      for (int i = 0; i < 2; i++)
        if (b_out.eofc == 0 || i < int'(b_out.eofc))
          b_got.push_back({b_out.eofc != 0 && i == int'(b_out.eofc) - 1, b_out.flag, b_out.data[i*8 +: 8]});
    if (c_in.valid && !c_in.stop)
      for (int i = 0; i < 16; i++)
        if (c_in.eofc == 0 || i < int'(c_in.eofc))
          c_exp.push_back({c_in.eofc != 0 && i == int'(c_in.eofc) - 1, c_in.flag, c_in.data[i*8 +: 8]});
    if (c_out.valid && !c_out.stop)
      for (int i = 0; i < 4; i++)
        if (c_out.eofc == 0 || i < int'(c_out.eofc))
          c_got.push_back({c_out.eofc != 0 && i == int'(c_out.eofc) - 1, c_out.flag, c_out.data[i*8 +: 8]});
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t t1[$];
    vec_t t2[$];
    int bad;
    a_in.valid = 0; a_in.eofc = 0; a_in.data = 0; a_in.flag = 0; a_out.stop = 0;
    b_in.valid = 0; b_in.eofc = 0; b_in.data = 0; b_in.flag = 0; b_out.stop = 0;
    c_in.valid = 0; c_in.eofc = 0; c_in.data = 0; c_in.flag = 0; c_out.stop = 0;
    repeat (2) @(negedge clk);
    check("rst_ov", 64'(a_out.valid), 64'd0);
    check("rst_is", 64'(a_in.stop), 64'd0);
    arstn = 1'b1;
    t1.push_back(vec(1, 8'd0, flit(8'h00), 0, 0, 0, 0, 32'h0, 8'd0, 0));
    t1.push_back(vec(1, 8'd0, flit(8'h08), 0, 0, 1, 1, 32'h03020100, 8'd0, 0));
    t1.push_back(vec(1, 8'd0, flit(8'h08), 0, 0, 0, 1, 32'h07060504, 8'd0, 0));
    t1.push_back(vec(1, 8'd8, flit(8'h10), 0, 0, 1, 1, 32'h0b0a0908, 8'd0, 0));
    t1.push_back(vec(1, 8'd8, flit(8'h10), 0, 0, 0, 1, 32'h0f0e0d0c, 8'd0, 0));
    t1.push_back(vec(1, 8'd3, flit(8'h20), 1, 0, 1, 1, 32'h13121110, 8'd0, 0));
    t1.push_back(vec(1, 8'd3, flit(8'h20), 1, 0, 0, 1, 32'h17161514, 8'd4, 0));
    t1.push_back(vec(1, 8'd5, flit(8'h30), 0, 0, 0, 1, 32'h23222120, 8'd3, 1));
    t1.push_back(vec(1, 8'd0, flit(8'h40), 1, 0, 1, 1, 32'h33323130, 8'd0, 0));
    t1.push_back(vec(1, 8'd0, flit(8'h40), 1, 0, 0, 1, 32'h37363534, 8'd1, 0));
    for (int i = 0; i < 5; i++) t1.push_back(vec(1, 8'd8, flit(8'h48), 1, 1, 1, 1, 32'h43424140, 8'd0, 1));
    t1.push_back(vec(1, 8'd8, flit(8'h48), 1, 0, 1, 1, 32'h43424140, 8'd0, 1));
    t1.push_back(vec(1, 8'd8, flit(8'h48), 1, 0, 0, 1, 32'h47464544, 8'd0, 1));
    t1.push_back(vec(1, 8'd8, flit(8'h50), 0, 0, 1, 1, 32'h4b4a4948, 8'd0, 1));
    t1.push_back(vec(1, 8'd8, flit(8'h50), 0, 0, 0, 1, 32'h4f4e4d4c, 8'd4, 1));
    t1.push_back(vec(0, 8'd0, 64'h0, 0, 0, 1, 1, 32'h53525150, 8'd0, 0));
    t1.push_back(vec(0, 8'd0, 64'h0, 0, 0, 0, 1, 32'h57565554, 8'd4, 0));
    t1.push_back(vec(0, 8'd0, 64'h0, 0, 0, 0, 0, 32'h0, 8'd0, 0));
    t1.push_back(vec(1, 8'd0, flit(8'h60), 0, 0, 0, 0, 32'h0, 8'd0, 0));
    t1.push_back(vec(0, 8'd0, 64'h0, 0, 0, 1, 1, 32'h63626160, 8'd0, 0));
    t1.push_back(vec(0, 8'd0, 64'h0, 0, 0, 0, 1, 32'h67666564, 8'd0, 0));
    foreach (t1[i]) run_vec($sformatf("c%0d", i), t1[i]);
    #1 arstn = 1'b0;
    #1;
    check("midrst_ov", 64'(a_out.valid), 64'd0);
    check("midrst_is", 64'(a_in.stop), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    t2.push_back(vec(1, 8'd6, flit(8'h70), 0, 0, 0, 0, 32'h0, 8'd0, 0));
    t2.push_back(vec(1, 8'd9, flit(8'h80), 1, 0, 1, 1, 32'h73727170, 8'd0, 0));
    t2.push_back(vec(1, 8'd9, flit(8'h80), 1, 0, 0, 1, 32'h77767574, 8'd2, 0));
    t2.push_back(vec(0, 8'd0, 64'h0, 0, 0, 1, 1, 32'h83828180, 8'd0, 1));
    t2.push_back(vec(0, 8'd0, 64'h0, 0, 0, 0, 1, 32'h87868584, 8'd4, 1));
    t2.push_back(vec(0, 8'd0, 64'h0, 0, 0, 0, 0, 32'h0, 8'd0, 0));
    foreach (t2[i]) run_vec($sformatf("r%0d", i), t2[i]);
    fork
      begin : drv_b
        int sent;
        logic st;
        sent = 0;
        st = 1'b1;
        for (int cyc = 0; cyc < 4000 && sent < NRAND; cyc++) begin
          @(negedge clk);
          if (b_in.valid && !st) begin
            b_in.valid = 0;
            sent++;
          end
          if (!b_in.valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
            b_in.valid = 1;
            b_in.data = {$urandom, $urandom};
            b_in.eofc = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 8)) : 8'd0;
            b_in.flag = 1'($urandom_range(0, 1));
          end
          b_out.stop = ($urandom_range(0, 3) == 0);
          #1 st = b_in.stop;
        end
        b_out.stop = 0;
        check("b_sent", 64'(sent), 64'(NRAND));
      end
      begin : drv_c
        int sent;
        logic st;
        sent = 0;
        st = 1'b1;
        for (int cyc = 0; cyc < 4000 && sent < NRAND; cyc++) begin
          @(negedge clk);
          if (c_in.valid && !st) begin
            c_in.valid = 0;
            sent++;
          end
          if (!c_in.valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
            c_in.valid = 1;
            c_in.data = {$urandom, $urandom, $urandom, $urandom};
            c_in.eofc = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 16)) : 8'd0;
            c_in.flag = 1'($urandom_range(0, 1));
          end
          c_out.stop = ($urandom_range(0, 3) == 0);
          #1 st = c_in.stop;
        end
        c_out.stop = 0;
        check("c_sent", 64'(sent), 64'(NRAND));
      end
    join
    repeat (60) @(negedge clk);
    check("b_nonempty", 64'(b_exp.size() > 0), 64'd1);
    check("b_len", 64'(b_got.size()), 64'(b_exp.size()));
    bad = 0;
    for (int i = 0; i < b_exp.size() && i < b_got.size(); i++) if (b_got[i] !== b_exp[i]) bad++;
    check("b_bytes_bad", 64'(bad), 64'd0);
    check("c_nonempty", 64'(c_exp.size() > 0), 64'd1);
    check("c_len", 64'(c_got.size()), 64'(c_exp.size()));
    bad = 0;
    for (int i = 0; i < c_exp.size() && i < c_got.size(); i++) if (c_got[i] !== c_exp[i]) bad++;
    check("c_bytes_bad", 64'(bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
